cam_wr_buffer: RTL and testbench
================================

# cam_wr_buffer

Write buffer between the camera capture stage and the DDR memory controller user interface. It accepts 256-bit pixel words with their word addresses from the capture stage, queues them in a small FIFO, and issues each one as a single write on the controller's command and write-data handshakes. It also reports when every word of a finished frame has been accepted by the controller, so downstream readers know a frame buffer is complete.

## Interface
**Parameters**
- `DEPTH`, default 16: FIFO entries; must be a power of 2, ≥ 4.
- `AW`, default 25: address width.

**Ports**
- `p_clk` in 1: single clock for the whole block.
- `rst_n` in 1: reset, asynchronous, active-low.
- `p_data` in 256: pixel word from capture.
- `data_valid` in 1: push strobe; one word per high cycle.
- `wr_address` in AW: word address paired with `p_data`.
- `frame_done` in 1: one-cycle pulse at end of frame.
- `app_en` out 1: command valid.
- `app_cmd` out 3: constant 3'b000 (write).
- `app_addr` out AW: command address.
- `app_rdy` in 1: command accepted when high together with `app_en`.
- `app_wdf_wren` out 1: write data valid.
- `app_wdf_data` out 256: write data.
- `app_wdf_end` out 1: equals `app_wdf_wren`; each word is a single-beat burst.
- `app_wdf_rdy` in 1: data accepted when high together with `app_wdf_wren`.
- `frame_written` out 1: one-cycle pulse when the last word of a frame is fully accepted.
- `overflow` out 1: sticky; a push was dropped because the FIFO was full.
- `fifo_level` out $clog2(DEPTH)+1: current FIFO occupancy.

## Operation
- **FIFO entry:** {last, wr_address, p_data}, 282 bits for the default `AW`.
- **Push:** happens on any `data_valid` cycle when the FIFO is not full. If the FIFO is full, the word is dropped, `overflow` is set to 1, and `fifo_level` is unchanged.
- **Last marking on `frame_done`:**
  - If a push happens in the same cycle, the pushed entry gets last = 1.
  - Otherwise, if the FIFO is non-empty, the most recently pushed entry gets last = 1.
  - Otherwise, if the output stage holds an un-retired word, that word's last flag is set.
  - Otherwise, `frame_written` pulses on the next cycle.
- **Output stage:** registers `app_addr`, `app_wdf_data` and a held last bit, plus the flags cmd_pend and data_pend.
- **FSM state IDLE:** `app_en` = `app_wdf_wren` = 0. If the FIFO is non-empty: pop the head, load the output registers, set both pend flags, and go to ISSUE.
- **FSM state ISSUE:**
  - cmd_pend clears on `app_en` && `app_rdy`.
  - data_pend clears on `app_wdf_wren` && `app_wdf_rdy`.
  - `app_en` = cmd_pend and `app_wdf_wren` = data_pend. Command and data complete independently, in either order, or in the same cycle.
  - **Retire:** the cycle in which the last outstanding pend flag clears.
  - On retire: if the FIFO is non-empty, pop and reload in the same cycle and stay in ISSUE (back-to-back); otherwise go to IDLE.
  - If the retired word had last = 1, `frame_written` pulses on the next cycle.
- **Held outputs:** `app_addr` and `app_wdf_data` are held constant from load until retire.
- **`fifo_level`:** increments on push and decrements on pop. On a simultaneous push and pop it is unchanged, including when the FIFO is full: a pop frees the slot in the same cycle, so the push is accepted. Read and write pointers wrap modulo `DEPTH`.

## Timing
- **Reset values (`rst_n` low, asynchronous):** FSM = IDLE; `app_en`, `app_wdf_wren`, `app_wdf_end`, `frame_written`, `overflow` = 0; `app_addr`, `app_wdf_data` = 0; `fifo_level` = 0; pointers = 0; pend flags = 0.
- **Reset mid-transfer:** asserting reset during a transfer abandons the held word and all queued words. No `frame_written` is generated for them.
- **Latency:** with the FIFO empty and the FSM in IDLE, `data_valid` high in cycle c gives `app_en` = `app_wdf_wren` = 1 in cycle c+2.
- **Throughput:** with `app_rdy` and `app_wdf_rdy` held high, sustained throughput is one word per cycle.
- **Pulse latency:** `frame_written` is high for exactly one cycle, at retire+1.
- **Constant outputs:** `app_cmd` is tied to 3'b000.

## Test plan
- **Single word:** push one word with addr 0x25800 and data 0xA5…A5, with both ready signals high → `app_en`/`app_wdf_wren` high in cycle c+2 only; `app_addr` = 0x25800; `fifo_level` returns to 0.
- **Split handshake:** `app_rdy` high at load+0, `app_wdf_rdy` delayed 3 cycles → `app_en` drops after 1 cycle; `app_wdf_wren` stays high 4 cycles with data stable; the next word loads on the retire cycle.
- **Overflow:** hold both ready signals low and push `DEPTH`+3 words (`DEPTH`=16) → `fifo_level` = 16 and `overflow` = 1 sticky. After releasing the ready signals, exactly 17 writes appear, with addresses 0, 8, … 128 in order.
- **Frame end:** push 8 words, then `frame_done` 2 cycles later, with ready toggling randomly → exactly one `frame_written` pulse, one cycle after the 8th word retires.
- **Simultaneous push and `frame_done`:** coincident with a full-FIFO pop → the word is accepted, it carries last = 1, and `frame_written` follows its retire.
- **Async reset:** assert `rst_n` low mid-ISSUE with 5 words queued → all outputs are at reset values immediately. After release, no writes occur and `frame_written` never pulses.

Source files
------------

// File: rtl/cam_wr_buffer.sv
// Write buffer from camera capture to the DDR controller user interface.
// Queues {last, addr, data} words and issues each as a single-beat write; flags completed frames.
module cam_wr_buffer #(
    parameter int DEPTH = 16,
    parameter int AW    = 25
) (
    input  logic                    p_clk,
    input  logic                    rst_n,
    input  logic [255:0]            p_data,
    input  logic                    data_valid,
    input  logic [AW-1:0]           wr_address,
    input  logic                    frame_done,
    output logic                    app_en,
    output logic [2:0]              app_cmd,
    output logic [AW-1:0]           app_addr,
    input  logic                    app_rdy,
    output logic                    app_wdf_wren,
    output logic [255:0]            app_wdf_data,
    output logic                    app_wdf_end,
    input  logic                    app_wdf_rdy,
    output logic                    frame_written,
    output logic                    overflow,
    output logic [$clog2(DEPTH):0]  fifo_level
);
    localparam int PW = $clog2(DEPTH);
    localparam int EW = AW + 256;

    typedef enum logic {IDLE, ISSUE} state_t;
    state_t state_q, state_d;

    logic [EW-1:0]    mem [DEPTH];
    logic [DEPTH-1:0] last_q;
    logic [PW-1:0]    wptr_q, rptr_q;
    logic             cmd_pend_q, data_pend_q, out_last_q;
    logic             full, empty, push, pop, retire;
    logic             cmd_done, data_done;
    logic             fd_mark_fifo, fd_mark_out, fd_idle, load_last;

    assign full  = fifo_level == (PW+1)'(DEPTH);
    assign empty = fifo_level == '0;
    // A pop in the same cycle frees a slot, so a push into a full FIFO is still taken.
    assign push  = data_valid && (!full || pop);

    assign cmd_done  = !cmd_pend_q || app_rdy;
    assign data_done = !data_pend_q || app_wdf_rdy;

    always_comb begin
        state_d = state_q;
        pop     = 1'b0;
        retire  = 1'b0;
        case (state_q)
            IDLE: begin
                if (!empty) begin
                    pop     = 1'b1;
                    state_d = ISSUE;
                end
            end
            ISSUE: begin
                if (cmd_done && data_done) begin
                    retire  = 1'b1;
                    pop     = !empty;
                    state_d = empty ? IDLE : ISSUE;
                end
            end
        endcase
    end

    // frame_done tags the newest word wherever it currently lives, or pulses directly if none is left.
    assign fd_mark_fifo = frame_done && !push && !empty;
    assign fd_mark_out  = frame_done && !push && empty && (state_q == ISSUE);
    assign fd_idle      = frame_done && !push && empty && (state_q == IDLE);
    // The newest entry may be the one being popped right now.
    assign load_last    = last_q[rptr_q] | (fd_mark_fifo && fifo_level == (PW+1)'(1));

    always_ff @(posedge p_clk) begin
        if (push) mem[wptr_q] <= {wr_address, p_data};
    end

    always_ff @(posedge p_clk or negedge rst_n) begin
        if (!rst_n) begin
            wptr_q     <= '0;
            rptr_q     <= '0;
            last_q     <= '0;
            fifo_level <= '0;
            overflow   <= 1'b0;
        end else begin
            if (push) begin
                last_q[wptr_q] <= frame_done;
                wptr_q         <= wptr_q + PW'(1);
            end else if (fd_mark_fifo) begin
                last_q[wptr_q - PW'(1)] <= 1'b1;
            end
            if (pop) rptr_q <= rptr_q + PW'(1);
            if (data_valid && !push) overflow <= 1'b1;
            case ({push, pop})
                2'b10:   fifo_level <= fifo_level + (PW+1)'(1);
                2'b01:   fifo_level <= fifo_level - (PW+1)'(1);
                default: fifo_level <= fifo_level;
            endcase
        end
    end

    always_ff @(posedge p_clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q       <= IDLE;
            app_addr      <= '0;
            app_wdf_data  <= '0;
            out_last_q    <= 1'b0;
            cmd_pend_q    <= 1'b0;
            data_pend_q   <= 1'b0;
            frame_written <= 1'b0;
        end else begin
            state_q       <= state_d;
            frame_written <= (retire && (out_last_q || fd_mark_out)) || fd_idle;
            if (pop) begin
                {app_addr, app_wdf_data} <= mem[rptr_q];
                out_last_q  <= load_last;
                cmd_pend_q  <= 1'b1;
                data_pend_q <= 1'b1;
            end else begin
                if (fd_mark_out) out_last_q  <= 1'b1;
                if (app_rdy)     cmd_pend_q  <= 1'b0;
                if (app_wdf_rdy) data_pend_q <= 1'b0;
            end
        end
    end

    assign app_en       = cmd_pend_q;
    assign app_wdf_wren = data_pend_q;
    assign app_wdf_end  = data_pend_q;
    assign app_cmd      = 3'b000;
endmodule

// File: tb/tb_cam_wr_buffer.sv
// Scoreboard bench for cam_wr_buffer: directed pushes queue expected writes, a monitor checks handshakes.
module tb_cam_wr_buffer;
    localparam int DEPTH = 16;
    localparam int AW    = 25;

    typedef struct {
        logic [AW-1:0] addr;
        logic [255:0]  data;
        logic          last;
    } exp_t;

    logic                   p_clk = 1'b0;
    logic                   rst_n = 1'b0;
    logic [255:0]           p_data;
    logic                   data_valid;
    logic [AW-1:0]          wr_address;
    logic                   frame_done;
    logic                   app_en;
    logic [2:0]             app_cmd;
    logic [AW-1:0]          app_addr;
    logic                   app_rdy;
    logic                   app_wdf_wren;
    logic [255:0]           app_wdf_data;
    logic                   app_wdf_end;
    logic                   app_wdf_rdy;
    logic                   frame_written;
    logic                   overflow;
    logic [$clog2(DEPTH):0] fifo_level;

    cam_wr_buffer #(.DEPTH(DEPTH), .AW(AW)) dut (
        .p_clk(p_clk), .rst_n(rst_n), .p_data(p_data), .data_valid(data_valid),
        .wr_address(wr_address), .frame_done(frame_done), .app_en(app_en),
        .app_cmd(app_cmd), .app_addr(app_addr), .app_rdy(app_rdy),
        .app_wdf_wren(app_wdf_wren), .app_wdf_data(app_wdf_data),
        .app_wdf_end(app_wdf_end), .app_wdf_rdy(app_wdf_rdy),
        .frame_written(frame_written), .overflow(overflow), .fifo_level(fifo_level)
    );

    always #5 p_clk = ~p_clk;

    exp_t exp_q[$];
    int   checks = 0, errors = 0;
    int   fw_cnt = 0, wr_cnt = 0, act_cnt = 0;
    logic cmd_got = 0, dat_got = 0, fw_exp = 0;

    task automatic chk(input string nm, input logic [255:0] act, input logic [255:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0h required %0h", nm, act, exp);
        end
    endtask

    function automatic logic [255:0] pat(input int a);
        return {8{32'hC0DE0000 ^ 32'(a)}};
    endfunction

    task automatic tick();
        @(posedge p_clk);
        #1;
    endtask

    task automatic put(input int a, input logic fd, input bit expect_it, input logic lst);
        exp_t e;
        data_valid = 1'b1;
        wr_address = AW'(a);
        p_data     = pat(a);
        frame_done = fd;
        if (expect_it) begin
            e.addr = AW'(a);
            e.data = pat(a);
            e.last = lst;
            exp_q.push_back(e);
        end
    endtask

    task automatic idle_in();
        data_valid = 1'b0;
        frame_done = 1'b0;
    endtask

    task automatic wait_drain(input int budget);
        int n = 0;
        while (exp_q.size() != 0 && n < budget) begin
            tick();
            n++;
        end
        checks++;
        if (exp_q.size() != 0) begin
            errors++;
            $display("FAIL drain_timeout: got %0d outstanding writes required 0", exp_q.size());
        end
        repeat (3) tick();
    endtask

    task automatic do_reset();
        rst_n = 1'b0;
        idle_in();
        tick();
        tick();
        exp_q.delete();
        rst_n = 1'b1;
        tick();
    endtask

    // Monitor: handshakes are sampled on the falling edge and take effect at the next rising edge.
    initial begin
        forever begin
            @(negedge p_clk);
            if (!rst_n) begin
                cmd_got = 0;
                dat_got = 0;
                fw_exp  = 0;
            end else begin
                if (frame_written) fw_cnt++;
                if (frame_written || fw_exp) chk("frame_written_timing", frame_written, fw_exp);
                fw_exp = 0;
                if (app_en || app_wdf_wren) begin
                    act_cnt++;
                    if (exp_q.size() == 0) begin
                        checks++;
                        errors++;
                        $display("FAIL unexpected_write: got addr %0h required no write", app_addr);
                    end else begin
                        chk("app_addr", app_addr, exp_q[0].addr);
                        if (app_wdf_wren) chk("app_wdf_data", app_wdf_data, exp_q[0].data);
                        chk("app_wdf_end", app_wdf_end, app_wdf_wren);
                        chk("app_cmd", app_cmd, 3'b000);
                        if (app_en && app_rdy) cmd_got = 1;
                        if (app_wdf_wren && app_wdf_rdy) dat_got = 1;
                        if (cmd_got && dat_got) begin
                            fw_exp = exp_q[0].last;
                            void'(exp_q.pop_front());
                            cmd_got = 0;
                            dat_got = 0;
                            wr_cnt++;
                        end
                    end
                end
            end
        end
    end

    initial begin
        #100000;
        $display("FAIL watchdog: got timeout required completion");
        $fatal(1);
    end

    initial begin
        int   fw0, wr0, act0;
        exp_t e;
        data_valid = 0; frame_done = 0; p_data = '0; wr_address = '0;
        app_rdy = 1; app_wdf_rdy = 1;
        repeat (2) @(posedge p_clk);
        @(negedge p_clk);
        chk("rst_app_en", app_en, 0);
        chk("rst_wdf_wren", app_wdf_wren, 0);
        chk("rst_wdf_end", app_wdf_end, 0);
        chk("rst_frame_written", frame_written, 0);
        chk("rst_overflow", overflow, 0);
        chk("rst_app_addr", app_addr, 0);
        chk("rst_wdf_data", app_wdf_data, 0);
        chk("rst_fifo_level", fifo_level, 0);
        tick();
        rst_n = 1;
        tick();

        // Single word: issue exactly in cycle c+2
        put(32'h25800, 0, 1, 0);
        p_data = {32{8'hA5}};
        exp_q[0].data = {32{8'hA5}};
        @(negedge p_clk); chk("t1_en_c0", app_en, 0);
        tick(); idle_in();
        @(negedge p_clk); chk("t1_en_c1", app_en, 0); chk("t1_level_c1", fifo_level, 1);
        @(negedge p_clk);
        chk("t1_en_c2", app_en, 1); chk("t1_wren_c2", app_wdf_wren, 1);
        chk("t1_addr_c2", app_addr, 25'h25800); chk("t1_level_c2", fifo_level, 0);
        @(negedge p_clk); chk("t1_en_c3", app_en, 0); chk("t1_wren_c3", app_wdf_wren, 0);
        wait_drain(20);

        // Split handshake: command accepted at once, data 3 cycles late
        app_wdf_rdy = 0;
        put(32'h100, 0, 1, 0);
        tick(); put(32'h200, 0, 1, 0);
        tick(); idle_in();
        @(negedge p_clk); chk("t2_en_L0", app_en, 1); chk("t2_wren_L0", app_wdf_wren, 1);
        @(negedge p_clk); chk("t2_en_L1", app_en, 0); chk("t2_data_L1", app_wdf_data, pat(32'h100));
        @(negedge p_clk); chk("t2_en_L2", app_en, 0); chk("t2_wren_L2", app_wdf_wren, 1);
        tick(); app_wdf_rdy = 1;
        @(negedge p_clk); chk("t2_wren_L3", app_wdf_wren, 1); chk("t2_data_L3", app_wdf_data, pat(32'h100));
        @(negedge p_clk);
        chk("t2_en_L4", app_en, 1); chk("t2_addr_L4", app_addr, 25'h200);
        chk("t2_data_L4", app_wdf_data, pat(32'h200));
        wait_drain(20);

        // Overflow: 19 pushes, 1 held in output stage + 16 queued, 2 dropped
        app_rdy = 0; app_wdf_rdy = 0;
        wr0 = wr_cnt;
        for (int i = 0; i < DEPTH + 3; i++) begin
            put(i * 8, 0, i < DEPTH + 1, 0);
            tick();
        end
        idle_in();
        @(negedge p_clk);
        chk("t3_level_full", fifo_level, 16); chk("t3_overflow", overflow, 1);
        chk("t3_held_addr", app_addr, 0);
        repeat (3) tick();
        @(negedge p_clk); chk("t3_level_hold", fifo_level, 16);
        tick(); app_rdy = 1; app_wdf_rdy = 1;
        wait_drain(60);
        chk("t3_write_count", wr_cnt - wr0, 17);
        chk("t3_overflow_sticky", overflow, 1);
        chk("t3_level_empty", fifo_level, 0);

        // Frame end with ready toggling
        fw0 = fw_cnt;
        for (int i = 0; i < 8; i++) begin
            put(32'h1000 + i, 0, 1, 0);
            app_rdy = 1'($urandom_range(0, 1)); app_wdf_rdy = 1'($urandom_range(0, 1));
            tick();
        end
        idle_in();
        app_rdy = 1'($urandom_range(0, 1)); app_wdf_rdy = 1'($urandom_range(0, 1));
        tick();
        frame_done = 1;
        e = exp_q[exp_q.size() - 1];
        e.last = 1;
        exp_q[exp_q.size() - 1] = e;
        app_rdy = 1'($urandom_range(0, 1)); app_wdf_rdy = 1'($urandom_range(0, 1));
        tick(); frame_done = 0;
        for (int i = 0; i < 40 && exp_q.size() != 0; i++) begin
            app_rdy = 1'($urandom_range(0, 1)); app_wdf_rdy = 1'($urandom_range(0, 1));
            tick();
        end
        app_rdy = 1; app_wdf_rdy = 1;
        wait_drain(40);
        chk("t4_frame_pulses", fw_cnt - fw0, 1);

        // Push + frame_done coincident with a pop from a full FIFO
        do_reset();
        chk("t5_overflow_clr", overflow, 0);
        app_rdy = 0; app_wdf_rdy = 0;
        for (int i = 0; i < DEPTH + 1; i++) begin
            put(32'h2000 + i, 0, 1, 0);
            tick();
        end
        idle_in();
        tick();
        @(negedge p_clk); chk("t5_level_full", fifo_level, 16);
        fw0 = fw_cnt;
        tick();
        app_rdy = 1; app_wdf_rdy = 1;
        put(32'h2011, 1, 1, 1);
        tick(); idle_in();
        @(negedge p_clk); chk("t5_level_same", fifo_level, 16); chk("t5_no_overflow", overflow, 0);
        wait_drain(40);
        chk("t5_frame_pulses", fw_cnt - fw0, 1);

        // Async reset mid-ISSUE with 5 queued words
        do_reset();
        app_rdy = 0; app_wdf_rdy = 0;
        for (int i = 0; i < 6; i++) begin
            put(32'h3000 + i, (i == 5), 1, (i == 5));
            tick();
        end
        idle_in();
        tick();
        @(negedge p_clk); chk("t6_level", fifo_level, 5); chk("t6_en", app_en, 1);
        #2 rst_n = 0;
        #1;
        chk("t6_rst_en", app_en, 0); chk("t6_rst_wren", app_wdf_wren, 0);
        chk("t6_rst_level", fifo_level, 0); chk("t6_rst_addr", app_addr, 0);
        chk("t6_rst_data", app_wdf_data, 0); chk("t6_rst_fw", frame_written, 0);
        exp_q.delete();
        fw0 = fw_cnt; act0 = act_cnt;
        tick(); tick();
        rst_n = 1; app_rdy = 1; app_wdf_rdy = 1;
        repeat (20) tick();
        chk("t6_no_writes", act_cnt - act0, 0);
        chk("t6_no_frame", fw_cnt - fw0, 0);
        chk("t6_level_after", fifo_level, 0);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end
endmodule
